// File: rtl/debounce_pulse.sv
// Button debouncer with a 2-flop synchronizer, single-cycle toggle pulse per accepted
// press, optional auto-repeat while held, and a wrapping 8-bit press counter.
`timescale 1ns/1ps

module debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_CYCLES   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       t,
    output logic       level,
    output logic [7:0] press_count
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam bit               RPT_EN   = (REPEAT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        CHK_RISE = 2'd1,
        ST_HIGH  = 2'd2,
        CHK_FALL = 2'd3
    } state_t;

    logic             r_s1, r_s2;
    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [CNT_W-1:0] r_rpt, w_rpt;
    logic             r_t, w_t;
    logic             r_level, w_level;
    logic [7:0]       r_count, w_count;
    logic             w_rpt_hit;

    assign w_rpt_hit = RPT_EN && (r_rpt == RPT_LAST);

    // Synchronizer and state/output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_rpt   <= '0;
            r_t     <= 1'b0;
            r_level <= 1'b0;
            r_count <= '0;
        end else begin
            r_s1    <= btn_in;
            r_s2    <= r_s1;
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_rpt   <= w_rpt;
            r_t     <= w_t;
            r_level <= w_level;
            r_count <= w_count;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_rpt   = r_rpt;
        w_t     = 1'b0;
        w_level = r_level;
        w_count = r_count;
        case (r_state)
            ST_LOW: begin
                if (r_s2) begin
                    w_state = CHK_RISE;
                    w_cnt   = CNT_W'(1);
                end else begin
                    w_cnt   = '0;
                end
            end
            CHK_RISE: begin
                if (!r_s2) begin
                    w_state = ST_LOW;
                    w_cnt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state = ST_HIGH;
                    w_level = 1'b1;
                    w_t     = 1'b1;
                    w_count = r_count + 8'd1;
                    w_cnt   = '0;
                    w_rpt   = '0;
                end else begin
                    w_cnt   = r_cnt + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                // A repeat expiring on the same edge as the release still fires
                if (w_rpt_hit) begin
                    w_t     = 1'b1;
                    w_count = r_count + 8'd1;
                    w_rpt   = '0;
                end else if (RPT_EN && r_s2) begin
                    w_rpt   = r_rpt + CNT_W'(1);
                end
                if (!r_s2) begin
                    w_state = CHK_FALL;
                    w_cnt   = CNT_W'(1);
                end
            end
            CHK_FALL: begin
                if (r_s2) begin
                    w_state = ST_HIGH;
                    w_cnt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state = ST_LOW;
                    w_level = 1'b0;
                    w_cnt   = '0;
                end else begin
                    w_cnt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state = ST_LOW;
                w_cnt   = '0;
            end
        endcase
    end

    assign t           = r_t;
    assign level       = r_level;
    assign press_count = r_count;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse: default instance plus a REPEAT_CYCLES=8 instance,
// pulse timing checked against per-instance queues of expected pulse edges.
`timescale 1ns/1ps

module tb_debounce_pulse;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn0, btn8;
    logic       t0, lvl0, t8, lvl8;
    logic [7:0] cnt0, cnt8;
    logic       q_tff;

    int cyc     = 0;
    int n_vec   = 0;
    int n_err   = 0;
    int pulses0 = 0;
    int exp0[$];
    int exp8[$];

    always #5 clk = ~clk;

    debounce_pulse u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn0),
        .t           (t0),
        .level       (lvl0),
        .press_count (cnt0)
    );

    debounce_pulse #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn8),
        .t           (t8),
        .level       (lvl8),
        .press_count (cnt8)
    );

    // Downstream toggle flip-flop driven by the default instance
    always @(posedge clk or posedge rst) begin
        if (rst) q_tff <= 1'b0;
        else if (t0) q_tff <= ~q_tff;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitor: every pulse must match the next expected edge number
    always @(negedge clk) begin
        if (t0 === 1'b1) begin
            pulses0++;
            if (exp0.size() == 0) chk("t0_unexpected_at_edge", cyc, -1);
            else chk("t0_pulse_edge", cyc, exp0.pop_front());
        end
        if (t8 === 1'b1) begin
            if (exp8.size() == 0) chk("t8_unexpected_at_edge", cyc, -1);
            else chk("t8_pulse_edge", cyc, exp8.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m, r, base;
        rst  = 1'b1;
        btn0 = 1'b0;
        btn8 = 1'b0;
        cycles(2);
        #1;
        chk("rst_t", int'(t0), 0);
        chk("rst_level", int'(lvl0), 0);
        chk("rst_count", int'(cnt0), 0);
        rst = 1'b0;
        cycles(3);

        // Clean press held 20 cycles
        m = cyc;
        exp0.push_back(m + 6);
        btn0 = 1'b1;
        cycles(20);
        chk("press_level", int'(lvl0), 1);
        chk("press_count", int'(cnt0), 1);
        chk("tff_q", int'(q_tff), 1);
        btn0 = 1'b0;
        cycles(10);
        chk("release_level", int'(lvl0), 0);

        // Short bounces never accepted
        btn0 = 1'b1; cycles(2);
        btn0 = 1'b0; cycles(1);
        btn0 = 1'b1; cycles(2);
        btn0 = 1'b0; cycles(10);
        chk("bounce_level", int'(lvl0), 0);
        chk("bounce_count", int'(cnt0), 1);

        // Release with a one-cycle high glitch
        m = cyc;
        exp0.push_back(m + 6);
        btn0 = 1'b1; cycles(10);
        btn0 = 1'b0; cycles(2);
        btn0 = 1'b1; cycles(1);
        btn0 = 1'b0; cycles(5);
        chk("glitch_level_held", int'(lvl0), 1);
        cycles(1);
        chk("glitch_level_drop", int'(lvl0), 0);
        chk("glitch_count", int'(cnt0), 2);
        cycles(5);

        // Auto-repeat: 40-cycle hold
        m = cyc;
        for (int i = 0; i < 5; i++) exp8.push_back(m + 6 + 8 * i);
        btn8 = 1'b1; cycles(40);
        btn8 = 1'b0; cycles(10);
        chk("rpt_count", int'(cnt8), 5);
        chk("rpt_level", int'(lvl8), 0);

        // Repeat expiry on the same edge the release is seen
        m = cyc;
        exp8.push_back(m + 6);
        exp8.push_back(m + 14);
        btn8 = 1'b1; cycles(11);
        btn8 = 1'b0; cycles(5);
        chk("rpt_fall_level_held", int'(lvl8), 1);
        cycles(1);
        chk("rpt_fall_level_drop", int'(lvl8), 0);
        chk("rpt_fall_count", int'(cnt8), 7);

        // Reset in CHK_RISE with cnt=3, button kept high across release
        m = cyc;
        btn0 = 1'b1; cycles(5);
        rst = 1'b1;
        #1;
        chk("rst_mid_t", int'(t0), 0);
        chk("rst_mid_level", int'(lvl0), 0);
        chk("rst_mid_count", int'(cnt0), 0);
        chk("rst_mid_count8", int'(cnt8), 0);
        cycles(2);
        chk("rst_hold_t", int'(t0), 0);
        r = cyc;
        exp0.push_back(r + 6);
        rst = 1'b0;
        cycles(6);
        #2;
        chk("post_rst_t_high", int'(t0), 1);
        chk("post_rst_count", int'(cnt0), 1);
        rst = 1'b1;
        #1;
        chk("rst_drops_t", int'(t0), 0);
        chk("rst_drops_count", int'(cnt0), 0);
        btn0 = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(3);

        // 256 presses: counter wraps
        base = pulses0;
        for (int i = 0; i < 256; i++) begin
            m = cyc;
            exp0.push_back(m + 6);
            btn0 = 1'b1; cycles(8);
            btn0 = 1'b0; cycles(8);
            if (i == 254) chk("count_255", int'(cnt0), 255);
        end
        chk("count_wrap", int'(cnt0), 0);
        chk("wrap_pulses", pulses0 - base, 256);

        chk("missed_pulses0", exp0.size(), 0);
        chk("missed_pulses8", exp8.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
